cp0_regfile: RTL and testbench

- Coprocessor 0 register file.
- Holds Count, Compare, Status, Cause and EPC. Runs the Count/Compare timer and samples hardware interrupt lines.
- Commits write-back `mtc0` writes and exception/ERET side effects.
- Drives `cp0_status`/`cp0_cause`/`cp0_epc` into the memory access stage, which forwards same-cycle WB writes on top of these registered values.

---
 rtl/cp0_regfile_if.sv | 34 +++
 rtl/cp0_regfile.sv | 105 ++++++++++
 tb/tb_cp0_regfile.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// Pipeline-to-CP0 bundle: WB writes, mfc0 read port, exception commit and CP0 state outputs.
interface cp0_regfile_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [5:0]            int_i;
    logic                  wb_wb_cp0;
    logic [4:0]            wb_cp0_write_addr;
    logic [DATA_WIDTH-1:0] wb_cp0_write;
    logic [4:0]            raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  except_valid;
    logic [4:0]            except_code;
    logic                  except_eret;
    logic [DATA_WIDTH-1:0] except_pc;
    logic                  except_in_delay_slot;
    logic [DATA_WIDTH-1:0] cp0_count;
    logic [DATA_WIDTH-1:0] cp0_compare;
    logic [DATA_WIDTH-1:0] cp0_status;
    logic [DATA_WIDTH-1:0] cp0_cause;
    logic [DATA_WIDTH-1:0] cp0_epc;
    logic                  timer_int;

    modport master (
        output int_i, wb_wb_cp0, wb_cp0_write_addr, wb_cp0_write, raddr,
               except_valid, except_code, except_eret, except_pc, except_in_delay_slot,
        input  rdata, cp0_count, cp0_compare, cp0_status, cp0_cause, cp0_epc, timer_int
    );

    modport slave (
        input  int_i, wb_wb_cp0, wb_cp0_write_addr, wb_cp0_write, raddr,
               except_valid, except_code, except_eret, except_pc, except_in_delay_slot,
        output rdata, cp0_count, cp0_compare, cp0_status, cp0_cause, cp0_epc, timer_int
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC with WB writes and exception/ERET commit.
module cp0_regfile #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    cp0_regfile_if.slave bus
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic [DATA_WIDTH-1:0] count_q,   count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic [DATA_WIDTH-1:0] status_q,  status_d;
    logic [DATA_WIDTH-1:0] cause_q,   cause_d;
    logic [DATA_WIDTH-1:0] epc_q,     epc_d;
    logic                  timer_q,   timer_d;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    always_comb begin
        wr_count   = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == ADDR_COUNT);
        wr_compare = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == ADDR_COMPARE);
        wr_status  = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == ADDR_STATUS);
        wr_cause   = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == ADDR_CAUSE);
        wr_epc     = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == ADDR_EPC);
    end

    // WB write applied first; exception/ERET then override only the fields they own.
    always_comb begin
        count_d   = count_q + DATA_WIDTH'(1);
        compare_d = compare_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        timer_d   = timer_q;

        if ((compare_q != '0) && (count_q == compare_q)) timer_d = 1'b1;
        cause_d[15:10] = {bus.int_i[5] | timer_q, bus.int_i[4:0]};

        if (wr_count) count_d = bus.wb_cp0_write;
        if (wr_compare) begin
            compare_d = bus.wb_cp0_write;
            timer_d   = 1'b0;
        end
        if (wr_status) status_d = bus.wb_cp0_write;
        if (wr_epc)    epc_d    = bus.wb_cp0_write;
        if (wr_cause) begin
            cause_d[9:8]   = bus.wb_cp0_write[9:8];
            cause_d[23:22] = bus.wb_cp0_write[23:22];
        end

        if (bus.except_eret) begin
            status_d[1] = 1'b0;
        end else if (bus.except_valid) begin
            if (!status_q[1]) begin
                epc_d       = bus.except_in_delay_slot ? (bus.except_pc - DATA_WIDTH'(4))
                                                       : bus.except_pc;
                cause_d[31] = bus.except_in_delay_slot;
            end
            cause_d[6:2] = bus.except_code;
            status_d[1]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end

    // mfc0 read port: registered values only, no WB forwarding.
    always_comb begin
        case (bus.raddr)
            ADDR_COUNT:   bus.rdata = count_q;
            ADDR_COMPARE: bus.rdata = compare_q;
            ADDR_STATUS:  bus.rdata = status_q;
            ADDR_CAUSE:   bus.rdata = cause_q;
            ADDR_EPC:     bus.rdata = epc_q;
            default:      bus.rdata = '0;
        endcase
    end

    assign bus.cp0_count   = count_q;
    assign bus.cp0_compare = compare_q;
    assign bus.cp0_status  = status_q;
    assign bus.cp0_cause   = cause_q;
    assign bus.cp0_epc     = epc_q;
    assign bus.timer_int   = timer_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations queued with stimulus, compared after the edge.
module tb_cp0_regfile;
    localparam int unsigned DW = 32;

    localparam int SEL_COUNT   = 0;
    localparam int SEL_COMPARE = 1;
    localparam int SEL_STATUS  = 2;
    localparam int SEL_CAUSE   = 3;
    localparam int SEL_EPC     = 4;
    localparam int SEL_TIMER   = 5;
    localparam int SEL_RDATA   = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    cp0_regfile_if #(.DATA_WIDTH(DW)) bus ();

    cp0_regfile #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_COUNT:   return bus.cp0_count;
            SEL_COMPARE: return bus.cp0_compare;
            SEL_STATUS:  return bus.cp0_status;
            SEL_CAUSE:   return bus.cp0_cause;
            SEL_EPC:     return bus.cp0_epc;
            SEL_TIMER:   return {31'd0, bus.timer_int};
            default:     return bus.rdata;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then compare every queued expectation against the settled outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        bus.wb_wb_cp0            = 1'b0;
        bus.wb_cp0_write_addr    = '0;
        bus.wb_cp0_write         = '0;
        bus.except_valid         = 1'b0;
        bus.except_eret          = 1'b0;
        bus.except_code          = '0;
        bus.except_pc            = '0;
        bus.except_in_delay_slot = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_wb_cp0         = 1'b1;
        bus.wb_cp0_write_addr = addr;
        bus.wb_cp0_write      = data;
    endtask

    task automatic except(input logic [4:0] code, input logic [31:0] pc, input logic ds);
        bus.except_valid         = 1'b1;
        bus.except_code          = code;
        bus.except_pc            = pc;
        bus.except_in_delay_slot = ds;
    endtask

    initial begin
        logic [31:0] cnt;
        rst       = 1'b1;
        bus.int_i = '0;
        bus.raddr = '0;
        idle();

        expect_out("rst_count", SEL_COUNT, 32'd0);
        expect_out("rst_compare", SEL_COMPARE, 32'd0);
        expect_out("rst_status", SEL_STATUS, 32'd0);
        expect_out("rst_cause", SEL_CAUSE, 32'd0);
        expect_out("rst_epc", SEL_EPC, 32'd0);
        expect_out("rst_timer", SEL_TIMER, 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            expect_out("idle_count", SEL_COUNT, 32'(i));
            tick();
        end
        expect_out("idle_status", SEL_STATUS, 32'd0);
        expect_out("idle_timer", SEL_TIMER, 32'd0);
        rst = 1'b1;
        expect_out("rerst_count", SEL_COUNT, 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 1; i <= 10; i++) tick();
        check("count_at_10", bus.cp0_count, 32'd10);

        // Compare = 20 written at Count = 10; fires on the edge after Count = 20.
        wb_write(5'd11, 32'd20);
        expect_out("cmp_written", SEL_COMPARE, 32'd20);
        expect_out("cmp_count", SEL_COUNT, 32'd11);
        tick();
        idle();
        cnt = 32'd11;
        while (cnt < 32'd21) begin
            cnt = cnt + 32'd1;
            expect_out("timer_count", SEL_COUNT, cnt);
            expect_out("timer_wait", SEL_TIMER, (cnt >= 32'd21) ? 32'd1 : 32'd0);
            tick();
        end
        expect_out("cause15_set", SEL_CAUSE, 32'h0000_8000);
        expect_out("timer_held", SEL_TIMER, 32'd1);
        tick();
        bus.raddr = 5'd11;
        #1 check("rdata_compare", bus.rdata, 32'd20);
        bus.raddr = 5'd5;
        #1 check("rdata_unmapped", bus.rdata, 32'd0);
        wb_write(5'd11, 32'd0);
        expect_out("timer_clear", SEL_TIMER, 32'd0);
        tick();
        idle();
        expect_out("cause15_clear", SEL_CAUSE, 32'd0);
        expect_out("cmp0_nofire", SEL_TIMER, 32'd0);
        tick();

        wb_write(5'd13, 32'hFFFF_FFFF);
        expect_out("cause_mask", SEL_CAUSE, 32'h00C0_0300);
        tick();
        idle();
        bus.int_i = 6'b000011;
        expect_out("cause_int", SEL_CAUSE, 32'h00C0_0F00);
        tick();
        bus.int_i = 6'b100000;
        expect_out("cause_ip7", SEL_CAUSE, 32'h00C0_8300);
        tick();
        bus.int_i = '0;
        expect_out("cause_int_off", SEL_CAUSE, 32'h00C0_0300);
        tick();

        except(5'h0C, 32'hBFC0_0100, 1'b1);
        expect_out("exc1_epc", SEL_EPC, 32'hBFC0_00FC);
        expect_out("exc1_cause", SEL_CAUSE, 32'h80C0_0330);
        expect_out("exc1_status", SEL_STATUS, 32'h0000_0002);
        tick();
        idle();
        except(5'h04, 32'h8000_0000, 1'b0);
        expect_out("exc2_epc", SEL_EPC, 32'hBFC0_00FC);
        expect_out("exc2_cause", SEL_CAUSE, 32'h80C0_0310);
        expect_out("exc2_status", SEL_STATUS, 32'h0000_0002);
        tick();
        idle();
        bus.except_eret = 1'b1;
        expect_out("eret_status", SEL_STATUS, 32'd0);
        expect_out("eret_epc", SEL_EPC, 32'hBFC0_00FC);
        expect_out("eret_cause", SEL_CAUSE, 32'h80C0_0310);
        tick();
        idle();

        // Both strobes high: ERET wins, exception fields untouched.
        wb_write(5'd12, 32'h0000_0002);
        tick();
        idle();
        except(5'h1F, 32'h1234_5678, 1'b1);
        bus.except_eret = 1'b1;
        expect_out("both_status", SEL_STATUS, 32'd0);
        expect_out("both_epc", SEL_EPC, 32'hBFC0_00FC);
        expect_out("both_cause", SEL_CAUSE, 32'h80C0_0310);
        tick();
        idle();

        bus.raddr = 5'd12;
        wb_write(5'd12, 32'h0000_FF01);
        except(5'h08, 32'h0000_0100, 1'b0);
        #1 check("rdata_nofwd", bus.rdata, 32'd0);
        expect_out("wbexc_status", SEL_STATUS, 32'h0000_FF03);
        expect_out("wbexc_rdata", SEL_RDATA, 32'h0000_FF03);
        expect_out("wbexc_epc", SEL_EPC, 32'h0000_0100);
        expect_out("wbexc_cause", SEL_CAUSE, 32'h00C0_0320);
        tick();
        idle();
        bus.raddr = 5'd14;
        wb_write(5'd14, 32'hDEAD_BEEF);
        expect_out("epc_write", SEL_RDATA, 32'hDEAD_BEEF);
        tick();
        idle();

        wb_write(5'd9, 32'hFFFF_FFFF);
        expect_out("count_load", SEL_COUNT, 32'hFFFF_FFFF);
        tick();
        idle();
        expect_out("count_wrap", SEL_COUNT, 32'd0);
        tick();
        wb_write(5'd9, 32'd7);
        expect_out("count_wr7", SEL_COUNT, 32'd7);
        tick();
        idle();
        expect_out("count_8", SEL_COUNT, 32'd8);
        tick();

        except(5'h0C, 32'h0000_0040, 1'b0);
        rst = 1'b1;
        expect_out("rstexc_status", SEL_STATUS, 32'd0);
        expect_out("rstexc_epc", SEL_EPC, 32'd0);
        expect_out("rstexc_cause", SEL_CAUSE, 32'd0);
        expect_out("rstexc_count", SEL_COUNT, 32'd0);
        tick();
        rst = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
